// File: rtl/athos_ip_perm_arb_if.sv
// Bundle of requester-side and datapath-side signals of the permutation arbiter.
// The arbiter uses the slave view; the requesters/datapath side uses the master view.
interface athos_ip_perm_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int OP_W    = 6
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      req_i;
    logic [NUM_REQ*OP_W-1:0] op_i;
    logic [NUM_REQ-1:0]      gnt_o;
    logic [NUM_REQ-1:0]      done_o;
    logic                    err_o;
    logic                    dp_start_o;
    logic [OP_W-1:0]         dp_operation_o;
    logic                    dp_ready_i;
    logic [SEL_W-1:0]        sel_o;
    logic                    busy_o;

    modport slave (
        input  req_i, op_i, dp_ready_i,
        output gnt_o, done_o, err_o, dp_start_o, dp_operation_o, sel_o, busy_o
    );

    modport master (
        output req_i, op_i, dp_ready_i,
        input  gnt_o, done_o, err_o, dp_start_o, dp_operation_o, sel_o, busy_o
    );
endinterface

// File: rtl/athos_ip_perm_arb.sv
// Round-robin arbiter/sequencer sharing one Keccak permutation datapath between
// several requesters, with a RUN-phase watchdog that aborts a stuck operation.
module athos_ip_perm_arb #(
    parameter int NUM_REQ     = 2,
    parameter int OP_W        = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    athos_ip_perm_arb_if.slave bus
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]  owner_q, owner_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] req_rot;
    logic [NUM_REQ-1:0] rot_first_oh;
    logic [SEL_W-1:0]   rot_off;
    logic [SEL_W:0]     pick_sum;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] owner_oh;
    logic [OP_W-1:0]    op_arr [NUM_REQ];

    // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit
    // of the rotated vector is then the round-robin winner.
    assign req_rot      = NUM_REQ'({bus.req_i, bus.req_i} >> rr_ptr_q);
    assign rot_first_oh = req_rot & (~req_rot + NUM_REQ'(1));

    for (genvar gi = 0; gi < SEL_W; gi++) begin : g_enc
        logic [NUM_REQ-1:0] bit_mask;
        for (genvar gj = 0; gj < NUM_REQ; gj++) begin : g_mask
            assign bit_mask[gj] = 1'(gj >> gi);
        end
        assign rot_off[gi] = |(rot_first_oh & bit_mask);
    end

    assign pick_sum = {1'b0, rr_ptr_q} + {1'b0, rot_off};
    assign pick_idx = (pick_sum >= (SEL_W+1)'(NUM_REQ))
                    ? SEL_W'(pick_sum - (SEL_W+1)'(NUM_REQ))
                    : pick_sum[SEL_W-1:0];

    assign rr_next = (owner_q == SEL_W'(NUM_REQ - 1)) ? '0 : owner_q + SEL_W'(1);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign op_arr[gi]   = bus.op_i[gi*OP_W +: OP_W];
        assign owner_oh[gi] = (owner_q == SEL_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req_i) begin
                    owner_d = pick_idx;
                    op_d    = op_arr[pick_idx];
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ready wins over a timeout landing in the same cycle.
                if (bus.dp_ready_i) begin
                    state_d = ST_DONE;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                rr_ptr_d = rr_next;
                err_d    = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.gnt_o          = (state_q != ST_IDLE) ? owner_oh : '0;
    assign bus.done_o         = (state_q == ST_DONE) ? owner_oh : '0;
    assign bus.err_o          = (state_q == ST_DONE) && err_q;
    assign bus.dp_start_o     = (state_q == ST_GRANT);
    assign bus.dp_operation_o = op_q;
    assign bus.sel_o          = owner_q;
    assign bus.busy_o         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_athos_ip_perm_arb.sv
// Scoreboard bench: a 2-requester arbiter (long watchdog) and a 4-requester
// arbiter (16-cycle watchdog), each driven against a small datapath model.
module tb_athos_ip_perm_arb;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int lat_a = 4;
    int lat_b = 3;
    int mode_a = 0;
    int mode_b = 0;

    typedef struct {
        int         idx;
        logic [5:0] op;
        bit         err;
    } exp_t;

    exp_t sb[$];

    athos_ip_perm_arb_if #(.NUM_REQ(2), .OP_W(6)) bus_a ();
    athos_ip_perm_arb_if #(.NUM_REQ(4), .OP_W(6)) bus_b ();

    athos_ip_perm_arb #(.NUM_REQ(2), .OP_W(6), .TIMEOUT_CYC(1024)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    athos_ip_perm_arb #(.NUM_REQ(4), .OP_W(6), .TIMEOUT_CYC(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: mode 0 answers lat cycles after start, 1 holds ready low, 2 holds it high.
    initial begin : dp_model_a
        int  s;
        bit  armed;
        s = 0;
        armed = 1'b0;
        bus_a.dp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_a.dp_start_o) begin
                armed = 1'b1;
                s = cyc;
            end
            if (mode_a == 1) bus_a.dp_ready_i = 1'b0;
            else if (mode_a == 2) bus_a.dp_ready_i = 1'b1;
            else begin
                bus_a.dp_ready_i = armed && (cyc == s + lat_a);
                if (bus_a.dp_ready_i) armed = 1'b0;
            end
        end
    end

    initial begin : dp_model_b
        int  s;
        bit  armed;
        s = 0;
        armed = 1'b0;
        bus_b.dp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_b.dp_start_o) begin
                armed = 1'b1;
                s = cyc;
            end
            if (mode_b == 1) bus_b.dp_ready_i = 1'b0;
            else if (mode_b == 2) bus_b.dp_ready_i = 1'b1;
            else begin
                bus_b.dp_ready_i = armed && (cyc == s + lat_b);
                if (bus_b.dp_ready_i) armed = 1'b0;
            end
        end
    end

    task automatic push_exp(input int idx, input logic [5:0] op, input bit err);
        exp_t e;
        e.idx = idx;
        e.op  = op;
        e.err = err;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a start pulse or any done pulse; counts extra starts seen meanwhile.
    task automatic wait_evt(input bit use_b, input bit want_done, input int budget,
                            output int at_cyc, output bit timed_out, output int extra_starts);
        bit hit;
        bit st;
        timed_out = 1'b1;
        at_cyc = -1;
        extra_starts = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            st  = use_b ? bus_b.dp_start_o : bus_a.dp_start_o;
            hit = want_done ? (use_b ? (|bus_b.done_o) : (|bus_a.done_o)) : st;
            if (want_done && st) extra_starts++;
            if (hit) begin
                timed_out = 1'b0;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.req_i = '0;
        bus_a.op_i  = '0;
        bus_b.req_i = '0;
        bus_b.op_i  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_a.gnt_o, bus_a.done_o, bus_a.err_o, bus_a.dp_start_o, bus_a.busy_o,
             bus_a.sel_o, bus_a.dp_operation_o} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs=%h required 0", {bus_a.gnt_o, bus_a.done_o, bus_a.err_o,
                     bus_a.dp_start_o, bus_a.busy_o, bus_a.sel_o, bus_a.dp_operation_o});
        end
        checks++;
        if ({bus_b.gnt_o, bus_b.done_o, bus_b.err_o, bus_b.dp_start_o, bus_b.busy_o,
             bus_b.sel_o, bus_b.dp_operation_o} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs=%h required 0", {bus_b.gnt_o, bus_b.done_o, bus_b.err_o,
                     bus_b.dp_start_o, bus_b.busy_o, bus_b.sel_o, bus_b.dp_operation_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_single();
        int t0, s, d, xs;
        bit to;
        exp_t e;
        lat_a = 24;
        bus_a.op_i  = {6'h3F, 6'h05};
        bus_a.req_i = 2'b01;
        push_exp(0, 6'h05, 1'b0);
        t0 = cyc;
        wait_evt(1'b0, 1'b0, 20, s, to, xs);
        checks++;
        if (to || s != t0 + 1) begin
            errors++;
            $display("FAIL single_start_latency: start cycle %0d required %0d", s, t0 + 1);
        end
        checks++;
        if (bus_a.gnt_o !== 2'b01 || bus_a.dp_operation_o !== 6'h05 || bus_a.sel_o !== 1'b0 || bus_a.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b op=%h sel=%b busy=%b required gnt=01 op=05 sel=0 busy=1",
                     bus_a.gnt_o, bus_a.dp_operation_o, bus_a.sel_o, bus_a.busy_o);
        end
        bus_a.op_i[5:0] = 6'h2A;
        wait_evt(1'b0, 1'b1, 100, d, to, xs);
        checks++;
        if (to || d != s + 25) begin
            errors++;
            $display("FAIL single_done_latency: done cycle %0d required %0d", d, s + 25);
        end
        checks++;
        if (xs != 0) begin
            errors++;
            $display("FAIL single_start_pulses: extra starts %0d required 0", xs);
        end
        e = sb.pop_front();
        checks++;
        if (bus_a.done_o !== 2'(1 << e.idx) || bus_a.err_o !== e.err || bus_a.dp_operation_o !== e.op) begin
            errors++;
            $display("FAIL single_done: done=%b err=%b op=%h required done=%b err=%b op=%h",
                     bus_a.done_o, bus_a.err_o, bus_a.dp_operation_o, 2'(1 << e.idx), e.err, e.op);
        end
        bus_a.req_i = 2'b00;
        @(negedge clk);
        checks++;
        if (bus_a.busy_o !== 1'b0 || bus_a.gnt_o !== 2'b00 || bus_a.done_o !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: busy=%b gnt=%b done=%b required 0 00 00",
                     bus_a.busy_o, bus_a.gnt_o, bus_a.done_o);
        end
        $display("single: req0 op=05 start@%0d done@%0d", s, d);
    endtask

    task automatic test_simultaneous();
        int s1, s2, d, xs;
        bit to;
        exp_t e;
        lat_a = 5;
        rst_n = 1'b0;
        bus_a.op_i  = {6'h22, 6'h11};
        bus_a.req_i = 2'b11;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp(0, 6'h11, 1'b0);
        push_exp(1, 6'h22, 1'b0);
        wait_evt(1'b0, 1'b0, 10, s1, to, xs);
        checks++;
        if (to || bus_a.gnt_o !== 2'b01 || bus_a.dp_operation_o !== 6'h11) begin
            errors++;
            $display("FAIL sim_first_grant: gnt=%b op=%h required gnt=01 op=11", bus_a.gnt_o, bus_a.dp_operation_o);
        end
        for (int k = 0; k < 2; k++) begin
            wait_evt(1'b0, 1'b1, 50, d, to, xs);
            e = sb.pop_front();
            checks++;
            if (to || bus_a.done_o !== 2'(1 << e.idx) || bus_a.err_o !== e.err || bus_a.dp_operation_o !== e.op) begin
                errors++;
                $display("FAIL sim_done%0d: done=%b err=%b op=%h required done=%b err=%b op=%h", k,
                         bus_a.done_o, bus_a.err_o, bus_a.dp_operation_o, 2'(1 << e.idx), e.err, e.op);
            end
            bus_a.req_i = (k == 0) ? 2'b10 : 2'b00;
            if (k == 0) begin
                wait_evt(1'b0, 1'b0, 20, s2, to, xs);
                checks++;
                if (to || s2 != s1 + 5 + 3) begin
                    errors++;
                    $display("FAIL sim_start_spacing: second start %0d required %0d", s2, s1 + 8);
                end
                checks++;
                if (bus_a.gnt_o !== 2'b10 || bus_a.dp_operation_o !== 6'h22 || bus_a.sel_o !== 1'b1) begin
                    errors++;
                    $display("FAIL sim_second_grant: gnt=%b op=%h sel=%b required 10 22 1",
                             bus_a.gnt_o, bus_a.dp_operation_o, bus_a.sel_o);
                end
            end
        end
        @(negedge clk);
        bus_a.req_i = 2'b11;
        push_exp(0, 6'h11, 1'b0);
        push_exp(1, 6'h22, 1'b0);
        wait_evt(1'b0, 1'b0, 10, s1, to, xs);
        checks++;
        if (to || bus_a.sel_o !== 1'b0 || bus_a.gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL sim_ptr_wrap: sel=%b gnt=%b required sel=0 gnt=01", bus_a.sel_o, bus_a.gnt_o);
        end
        for (int k = 0; k < 2; k++) begin
            wait_evt(1'b0, 1'b1, 50, d, to, xs);
            e = sb.pop_front();
            checks++;
            if (to || bus_a.done_o !== 2'(1 << e.idx)) begin
                errors++;
                $display("FAIL sim_wrap_done%0d: done=%b required %b", k, bus_a.done_o, 2'(1 << e.idx));
            end
            bus_a.req_i = (k == 0) ? 2'b10 : 2'b00;
        end
        @(negedge clk);
        $display("simultaneous: req0 start@%0d then req1 start@%0d", s1, s2);
    endtask

    task automatic test_fairness();
        int   ndone;
        int   multi;
        exp_t e;
        lat_b = 3;
        mode_b = 0;
        bus_b.op_i = {6'h04, 6'h03, 6'h02, 6'h01};
        for (int k = 0; k < 8; k++) push_exp(k % 4, 6'((k % 4) + 1), 1'b0);
        bus_b.req_i = 4'hF;
        ndone = 0;
        multi = 0;
        for (int n = 0; n < 300 && ndone < 8; n++) begin
            @(negedge clk);
            if ($countones(bus_b.gnt_o) > 1) multi++;
            if (|bus_b.done_o) begin
                e = sb.pop_front();
                checks++;
                if (bus_b.done_o !== 4'(1 << e.idx) || bus_b.dp_operation_o !== e.op || bus_b.sel_o !== 2'(e.idx)) begin
                    errors++;
                    $display("FAIL fair_order%0d: done=%b op=%h sel=%0d required done=%b op=%h sel=%0d", ndone,
                             bus_b.done_o, bus_b.dp_operation_o, bus_b.sel_o, 4'(1 << e.idx), e.op, e.idx);
                end
                $display("fairness: op %0d served requester %0d", ndone, bus_b.sel_o);
                ndone++;
                if (ndone == 8) bus_b.req_i = 4'h0;
            end
        end
        checks++;
        if (ndone != 8) begin
            errors++;
            $display("FAIL fair_count: completions %0d required 8", ndone);
            sb.delete();
            bus_b.req_i = 4'h0;
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL fair_onehot: multi-hot cycles %0d required 0", multi);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_watchdog();
        int s, d, xs;
        bit to;
        exp_t e;
        mode_b = 1;
        bus_b.op_i[17:12] = 6'h33;
        push_exp(2, 6'h33, 1'b1);
        bus_b.req_i = 4'b0100;
        wait_evt(1'b1, 1'b0, 10, s, to, xs);
        checks++;
        if (to || bus_b.gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL wd_grant: gnt=%b required 0100", bus_b.gnt_o);
        end
        wait_evt(1'b1, 1'b1, 60, d, to, xs);
        checks++;
        if (to || d != s + 17) begin
            errors++;
            $display("FAIL wd_latency: abort cycle %0d required %0d", d, s + 17);
        end
        e = sb.pop_front();
        checks++;
        if (bus_b.done_o !== 4'(1 << e.idx) || bus_b.err_o !== e.err || bus_b.dp_operation_o !== e.op) begin
            errors++;
            $display("FAIL wd_abort: done=%b err=%b op=%h required done=%b err=%b op=%h",
                     bus_b.done_o, bus_b.err_o, bus_b.dp_operation_o, 4'(1 << e.idx), e.err, e.op);
        end
        bus_b.req_i = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus_b.busy_o !== 1'b0 || bus_b.err_o !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: busy=%b err=%b required 0 0", bus_b.busy_o, bus_b.err_o);
        end
        $display("watchdog: start@%0d abort@%0d", s, d);
        mode_b = 2;
        repeat (3) @(negedge clk);
        bus_b.op_i[11:6] = 6'h3C;
        push_exp(1, 6'h3C, 1'b0);
        bus_b.req_i = 4'b0010;
        wait_evt(1'b1, 1'b0, 10, s, to, xs);
        wait_evt(1'b1, 1'b1, 40, d, to, xs);
        checks++;
        if (to || d != s + 2) begin
            errors++;
            $display("FAIL stale_ready: done cycle %0d required %0d", d, s + 2);
        end
        e = sb.pop_front();
        checks++;
        if (bus_b.done_o !== 4'(1 << e.idx) || bus_b.err_o !== e.err || bus_b.dp_operation_o !== e.op) begin
            errors++;
            $display("FAIL stale_done: done=%b err=%b op=%h required done=%b err=%b op=%h",
                     bus_b.done_o, bus_b.err_o, bus_b.dp_operation_o, 4'(1 << e.idx), e.err, e.op);
        end
        bus_b.req_i = 4'b0000;
        mode_b = 0;
        repeat (2) @(negedge clk);
        $display("stale_ready: start@%0d done@%0d", s, d);
    endtask

    task automatic test_req_drop();
        int s, d, xs;
        bit to;
        exp_t e;
        lat_a = 6;
        bus_a.op_i[11:6] = 6'h07;
        push_exp(1, 6'h07, 1'b0);
        bus_a.req_i = 2'b10;
        wait_evt(1'b0, 1'b0, 10, s, to, xs);
        @(negedge clk);
        bus_a.req_i = 2'b00;
        wait_evt(1'b0, 1'b1, 40, d, to, xs);
        checks++;
        if (to || d != s + 7) begin
            errors++;
            $display("FAIL drop_latency: done cycle %0d required %0d", d, s + 7);
        end
        e = sb.pop_front();
        checks++;
        if (bus_a.done_o !== 2'(1 << e.idx) || bus_a.dp_operation_o !== e.op) begin
            errors++;
            $display("FAIL drop_done: done=%b op=%h required done=%b op=%h",
                     bus_a.done_o, bus_a.dp_operation_o, 2'(1 << e.idx), e.op);
        end
        @(negedge clk);
        $display("req_drop: start@%0d done@%0d", s, d);
    endtask

    task automatic test_reset_mid_run();
        int s, xs, spurious;
        bit to;
        lat_a = 10;
        bus_a.op_i[5:0] = 6'h15;
        bus_a.req_i = 2'b01;
        wait_evt(1'b0, 1'b0, 10, s, to, xs);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        bus_a.req_i = 2'b00;
        @(negedge clk);
        checks++;
        if ({bus_a.gnt_o, bus_a.done_o, bus_a.err_o, bus_a.dp_start_o, bus_a.busy_o,
             bus_a.sel_o, bus_a.dp_operation_o} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: outputs=%h required 0", {bus_a.gnt_o, bus_a.done_o, bus_a.err_o,
                     bus_a.dp_start_o, bus_a.busy_o, bus_a.sel_o, bus_a.dp_operation_o});
        end
        rst_n = 1'b1;
        spurious = 0;
        repeat (30) begin
            @(negedge clk);
            if ((|bus_a.done_o) || bus_a.err_o || bus_a.busy_o) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midrun_no_done: spurious cycles %0d required 0", spurious);
        end
        $display("reset_mid_run: aborted op started @%0d", s);
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_watchdog();
        test_req_drop();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/athos_ip_perm_arb.md
# athos_ip_perm_arb

Round-robin arbiter and sequencer that shares the single Keccak permutation datapath (`athos_ip_dp`) between several requesters, e.g. the register-file control unit and a DMA/streaming front end. It owns the datapath `start_i`/`operation_i` inputs and watches its `ready_o`. It grants exactly one requester at a time and drives a select index for the external data muxes. It returns a per-requester done pulse, and returns an error pulse through a watchdog if the datapath never completes.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `OP_W`, default 6: operation code width; matches the datapath `operation_i`.
- `TIMEOUT_CYC`, default 1024: maximum RUN cycles before abort; 0 disables the watchdog.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_i`  in  NUM_REQ  request; level, held by the requester until its `done_o`.
- `op_i`  in  NUM_REQ*OP_W  per-requester operation code; slice k belongs to requester k.
- `gnt_o`  out  NUM_REQ  one-hot grant; high from GRANT through DONE.
- `done_o`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `err_o`  out  1  one-cycle watchdog abort pulse; coincides with `done_o[owner]`.
- `dp_start_o`  out  1  one-cycle start pulse to the datapath.
- `dp_operation_o`  out  OP_W  latched operation of the owner; stable from GRANT until the next grant.
- `dp_ready_i`  in  1  datapath done/ready.
- `sel_o`  out  $clog2(NUM_REQ)  owner index for the external data muxes.
- `busy_o`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, GRANT, RUN, DONE.
- **IDLE**
  - If any `req_i` is set, pick the first requester at or after `rr_ptr`, scanning upward and wrapping.
  - Latch its index into owner/`sel_o` and its `op_i` slice into `dp_operation_o`.
  - Go to GRANT.
- **GRANT**, one cycle
  - `gnt_o[owner]`=1, `dp_start_o`=1.
  - Clear the watchdog counter. Go to RUN.
- **RUN**
  - `gnt_o[owner]`=1. The counter increments every cycle.
  - `dp_ready_i`=1: go to DONE.
  - Counter reaches TIMEOUT_CYC-1 with `dp_ready_i`=0 (and TIMEOUT_CYC≠0): go to DONE with the error flag set.
- **DONE**, one cycle
  - `done_o[owner]`=1, `err_o`=error flag, `gnt_o[owner]`=1.
  - `rr_ptr` ← (owner+1) mod NUM_REQ. Clear the error flag. Go to IDLE.
- Requester rules:
  - `req_i[owner]` deasserting during GRANT/RUN is ignored; the operation completes and `done_o` still pulses.
  - `op_i` changes after the IDLE sample have no effect.
- Datapath rules:
  - `dp_ready_i` during IDLE/GRANT is ignored; it is stale status from the previous operation.
  - `dp_ready_i` in DONE is ignored.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 operations.
- Out-of-range owner indices cannot occur: the scan covers only 0..NUM_REQ-1.

## Timing
- Reset values (`rst_n`=0 at a rising edge):
  - state=IDLE, `rr_ptr`=0, owner/`sel_o`=0, `dp_operation_o`=0, watchdog counter=0, error flag=0.
  - `gnt_o`=0, `done_o`=0, `err_o`=0, `dp_start_o`=0, `busy_o`=0.
- Reset mid-operation: all outputs reach their reset values at the next edge; no `done_o`/`err_o` is emitted for the aborted operation.
- Latency from request to start: `req_i` is sampled high in IDLE at edge t; `dp_start_o` and `gnt_o` are high in cycle t+1.
- Latency from datapath ready to done: `dp_ready_i` is seen in RUN at edge u; `done_o` is high in cycle u+1; state is IDLE in cycle u+2.
- Minimum gap between back-to-back operations: the next grant is decided in IDLE at cycle u+2, so its `dp_start_o` is at u+3. Minimum start-to-start spacing = datapath latency + 3 cycles.
- Watchdog: with TIMEOUT_CYC=N, abort happens when the N-th RUN cycle ends without ready; `err_o` is in the following cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from `req_i`/`dp_ready_i` to any output.

## Test plan
- **Single request:** NUM_REQ=2; `req_i`=01, `op_i[0]`=6'h05; datapath returns ready 24 cycles after start.
  - Required: `gnt_o`=01, `dp_start_o` pulses once, `dp_operation_o`=05, `sel_o`=0.
  - Required: `done_o`=01 one cycle after ready; `busy_o` drops the cycle after that.
- **Simultaneous requests:** `req_i`=11 from reset.
  - Required: requester 0 is served first, then requester 1.
  - Required: second `dp_start_o` exactly 3 cycles after the first `dp_ready_i`.
  - Required: `rr_ptr` ends at 0.
- **Fairness:** NUM_REQ=4 with all requests held for 8 operations.
  - Required: grant order 0,1,2,3,0,1,2,3; `gnt_o` is never multi-hot.
- **Watchdog:** TIMEOUT_CYC=16 and `dp_ready_i` held at 0.
  - Required: `err_o` and `done_o[owner]` pulse together 17 cycles after `dp_start_o`; state returns to IDLE.
  - Then, with `dp_ready_i` held at 1 during IDLE/GRANT (stale ready): no premature done; the RUN cycle sees ready and completes normally.
- **Reset and request-drop:** assert `rst_n`=0 during RUN.
  - Required: all outputs are 0 at the next edge; no `done_o`.
  - Separately, drop `req_i[owner]` during RUN: `done_o` still pulses on ready.
